add_sub_serial: RTL and testbench
=================================

ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter SLICE, default 2, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE, and N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 busy  output  1  high while slices are being computed.
REQ-010 done  output  1  one-cycle pulse; result and flags valid.
REQ-011 sum  output  WIDTH  result, held until next accepted start.
REQ-012 cout  output  1  unsigned carry out of MSB; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed overflow.
REQ-014 zero  output  1  high when the final sum equals 0.

Function
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: start=1 latches a, b XOR {WIDTH{sub}}, and carry=sub into internal registers, clears the slice counter, and moves to BUSY; start=0 stays in IDLE.
REQ-017 BUSY: each cycle adds one SLICE-bit slice (LSB slice first) with the running carry, stores the slice result, and increments the counter; after exactly N BUSY cycles the FSM moves to DONE.
REQ-018 DONE: exactly one cycle, then IDLE; sum/cout/ovf/zero update on the edge entering DONE and hold until the edge entering DONE of the next operation.
REQ-019 Latency: start sampled at edge k -> busy high for cycles k+1..k+N -> done high for cycle k+N+1 only.
REQ-020 busy = 1 only in BUSY; done = 1 only in DONE.
REQ-021 start in BUSY or DONE is ignored; operand inputs changing after acceptance have no effect.
REQ-022 start held high continuously restarts on each return to IDLE, giving a throughput of one result per N+2 cycles.
REQ-023 ovf = carry into MSB XOR carry out of MSB; cout = final carry; all arithmetic is modulo 2^WIDTH.
REQ-024 zero is evaluated on the final (post-saturation) sum.

Reset
REQ-025 rst=1 at an edge forces IDLE and clears busy, done, sum, cout, ovf, zero, counter and internal registers to 0, regardless of state.
REQ-026 rst has priority over start; an operation interrupted by reset produces no done pulse.

Configuration
REQ-027 Macro ADD_SUB_SAT_EN defined: when ovf=1, sum saturates to 0 followed by all ones (max positive) if the latched A MSB is 0, otherwise to 1 followed by all zeros (min negative); ovf and cout still report the unsaturated condition.
REQ-028 ADD_SUB_SAT_EN undefined: sum always equals the wrapped result and there is no saturation logic.

Verification (WIDTH=8, SLICE=2, N=4)
REQ-029 a=35h, b=1Ah, sub=0 -> sum=4Fh, cout=0, ovf=0, zero=0; busy for 4 cycles, done exactly 5 cycles after the start edge.
REQ-030 a=10h, b=10h, sub=1 -> sum=00h, cout=1, ovf=0, zero=1; a=FFh, b=01h, sub=0 -> sum=00h, cout=1, ovf=0, zero=1.
REQ-031 a=7Fh, b=01h, sub=0 -> ovf=1, cout=0; sum=80h without the macro, 7Fh with ADD_SUB_SAT_EN.
REQ-032 a=80h, b=01h, sub=1 -> ovf=1, cout=1; sum=7Fh without the macro, 80h with ADD_SUB_SAT_EN.
REQ-033 Pulse start again with new operands during BUSY -> ignored; the first result is delivered unchanged and only one done pulse occurs.
REQ-034 Assert rst during the 2nd BUSY cycle -> next cycle busy=0, done=0, sum=00h, all flags 0; no done pulse follows.

Source files
------------

// File: rtl/add_sub_serial.sv
// Serial adder/subtractor: WIDTH-bit operands processed SLICE bits per clock, N = WIDTH/SLICE BUSY cycles.
// Latency N+1 cycles from accepted start to the done pulse; no backpressure, start is ignored while busy.
// Optional saturation of signed overflow when ADD_SUB_SAT_EN is defined.
module add_sub_serial #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]       a_r, b_r, res_r;
   logic                   carry;
   logic                   a_msb_r, b_msb_r;
   logic [CW-1:0]          cnt;
   logic                   last;
   logic [SLICE:0]         slice_add;
   logic [WIDTH+SLICE-1:0] res_cat;
   logic [WIDTH-1:0]       res_nxt;
   logic                   ovf_nxt;
   logic [WIDTH-1:0]       sum_nxt;

   assign last      = (cnt == CW'(N - 1));
   assign slice_add = {1'b0, a_r[SLICE-1:0]} + {1'b0, b_r[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
   // New slice enters at the top; after N slices the LSB slice has reached bit 0.
   assign res_cat   = {slice_add[SLICE-1:0], res_r};
   assign res_nxt   = res_cat[WIDTH+SLICE-1:SLICE];
   // Carry into the MSB is recovered as a ^ b ^ sum at the MSB.
   assign ovf_nxt   = a_msb_r ^ b_msb_r ^ res_nxt[WIDTH-1] ^ slice_add[SLICE];

`ifdef ADD_SUB_SAT_EN
   always_comb begin
      sum_nxt = res_nxt;
      if (ovf_nxt)
         sum_nxt = a_msb_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign sum_nxt = res_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = BUSY;
         BUSY: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry   <= 1'b0;
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r     <= a;
               b_r     <= b ^ {WIDTH{sub}};
               carry   <= sub;
               a_msb_r <= a[WIDTH-1];
               b_msb_r <= b[WIDTH-1] ^ sub;
               cnt     <= '0;
            end
            BUSY: begin
               a_r   <= a_r >> SLICE;
               b_r   <= b_r >> SLICE;
               carry <= slice_add[SLICE];
               res_r <= res_nxt;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= sum_nxt;
                  cout <= slice_add[SLICE];
                  ovf  <= ovf_nxt;
                  zero <= (sum_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial at WIDTH=8, SLICE=2 (N=4): timing, results, flags, ignore-start, restart, reset.
module tb_add_sub_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       sub;
   logic       busy, done, cout, ovf, zero;
   logic [7:0] sum;

   int total = 0;
   int bad   = 0;

   add_sub_serial #(.WIDTH(8), .SLICE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation and checks busy/done timing and the final result.
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                         input logic [7:0] esum, input logic ecout, input logic eovf, input logic ezero);
      a = ia; b = ib; sub = isub; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'h5A; b = 8'hC3; sub = ~isub;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_nodone"}, done, 0);
         tick();
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_sum"}, sum, esum);
      chk({tag, "_cout"}, cout, ecout);
      chk({tag, "_ovf"}, ovf, eovf);
      chk({tag, "_zero"}, zero, ezero);
      tick();
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_hold"}, sum, esum);
   endtask

   initial begin
      int dones;
      int t1;
      int t2;
      logic [7:0] e7f, e80;
`ifdef ADD_SUB_SAT_EN
      e7f = 8'h7F; e80 = 8'h80;
`else
      e7f = 8'h80; e80 = 8'h7F;
`endif
      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_flags", {cout, ovf, zero}, 0);
      rst = 1'b0;
      tick();

      run_op("add35_1a", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0, 1'b0);
      run_op("sub10_10", 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      run_op("add7f_01", 8'h7F, 8'h01, 1'b0, e7f,   1'b0, 1'b1, 1'b0);
      run_op("sub80_01", 8'h80, 8'h01, 1'b1, e80,   1'b1, 1'b1, 1'b0);
      run_op("sub05_09", 8'h05, 8'h09, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);

      // Second start during BUSY must be ignored.
      a = 8'h35; b = 8'h1A; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            dones++;
            chk("ignore_sum", sum, 8'h4F);
         end
         tick();
      end
      chk("ignore_dones", dones, 1);

      // Held start: back-to-back results every N+2 cycles.
      a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
      t1 = -1; t2 = -1;
      for (int i = 0; i < 20 && t2 < 0; i++) begin
         tick();
         if (done) begin
            if (t1 < 0) t1 = i; else t2 = i;
         end
      end
      start = 1'b0;
      chk("hold_found", (t1 >= 0 && t2 >= 0), 1);
      chk("hold_period", t2 - t1, 6);
      chk("hold_sum", sum, 8'h03);
      for (int i = 0; i < 8; i++) tick();
      chk("hold_idle", {busy, done}, 0);

      // Reset in the 2nd BUSY cycle after a result with nonzero sum and flags.
      run_op("pre_rst", 8'h80, 8'h01, 1'b1, e80, 1'b1, 1'b1, 1'b0);
      a = 8'h35; b = 8'h1A; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_flags", {cout, ovf, zero}, 0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) dones++;
         tick();
      end
      chk("mid_rst_quiet", dones, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
